// File: rtl/load_arbiter_if.sv
// rtl/load_arbiter_if.sv - request/grant bundle between the load requesters and the arbiter.
interface load_arbiter_if;
   logic       H;
   logic       DC;
   logic       C;
   logic       GH;
   logic       GDC;
   logic       GC;
   logic [1:0] OWNER;
   logic       BUSY;
   logic       SWITCH;

   modport master (
      output H, DC, C,
      input  GH, GDC, GC, OWNER, BUSY, SWITCH
   );

   modport slave (
      input  H, DC, C,
      output GH, GDC, GC, OWNER, BUSY, SWITCH
   );
endinterface

// File: rtl/load_arbiter.sv
// rtl/load_arbiter.sv - round-robin time-sharing of one actuator channel among H, DC and C
// with minimum on-time, pre-emption slice and dead-time gap.
module load_arbiter #(
   parameter int MIN_ON = 4,
   parameter int MAX_ON = 16,
   parameter int GAP    = 2,
   parameter int CW     = 5
) (
   input  logic          CLK,
   input  logic          reset_n,
   load_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_GRANT = 2'b01,
      S_GAP   = 2'b10
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_H    = 2'b01;
   localparam logic [1:0] OWN_DC   = 2'b10;
   localparam logic [1:0] OWN_C    = 2'b11;

   state_t        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic [1:0]    last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] gcnt_q, gcnt_d;
   logic [2:0]    grant_q, grant_d;
   logic          busy_q, busy_d;
   logic          switch_q, switch_d;

   logic [2:0]    req;
   logic [1:0]    win;
   logic          own_req;
   logic          others;
   logic          release_now;
   logic          preempt_now;

   // Search starts at the load just after the previous owner.
   function automatic logic [1:0] pick(input logic [1:0] last, input logic [2:0] r);
      logic [1:0] res;
      res = OWN_NONE;
      case (last)
         OWN_H: begin
            if (r[1])      res = OWN_DC;
            else if (r[2]) res = OWN_C;
            else if (r[0]) res = OWN_H;
         end
         OWN_DC: begin
            if (r[2])      res = OWN_C;
            else if (r[0]) res = OWN_H;
            else if (r[1]) res = OWN_DC;
         end
         default: begin
            if (r[0])      res = OWN_H;
            else if (r[1]) res = OWN_DC;
            else if (r[2]) res = OWN_C;
         end
      endcase
      return res;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] own);
      logic [2:0] res;
      case (own)
         OWN_H:   res = 3'b001;
         OWN_DC:  res = 3'b010;
         OWN_C:   res = 3'b100;
         default: res = 3'b000;
      endcase
      return res;
   endfunction

   assign req         = {bus.C, bus.DC, bus.H};
   assign win         = pick(last_q, req);
   assign own_req     = |(req & onehot(owner_q));
   assign others      = |(req & ~onehot(owner_q));
   assign release_now = !own_req && (cnt_q >= CW'(MIN_ON));
   assign preempt_now = others && (cnt_q >= CW'(MAX_ON));

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      gcnt_d   = gcnt_q;
      grant_d  = grant_q;
      busy_d   = busy_q;
      switch_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            owner_d = OWN_NONE;
            grant_d = 3'b000;
            busy_d  = 1'b0;
            if (win != OWN_NONE) begin
               state_d  = S_GRANT;
               owner_d  = win;
               grant_d  = onehot(win);
               cnt_d    = CW'(1);
               busy_d   = 1'b1;
               switch_d = 1'b1;
            end
         end
         S_GRANT: begin
            busy_d = 1'b1;
            if (release_now || preempt_now) begin
               state_d = S_GAP;
               last_d  = owner_q;
               owner_d = OWN_NONE;
               grant_d = 3'b000;
               gcnt_d  = CW'(1);
            end else if (cnt_q < CW'(MAX_ON)) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            busy_d  = 1'b1;
            owner_d = OWN_NONE;
            grant_d = 3'b000;
            if (gcnt_q >= CW'(GAP)) begin
               if (win != OWN_NONE) begin
                  state_d  = S_GRANT;
                  owner_d  = win;
                  grant_d  = onehot(win);
                  cnt_d    = CW'(1);
                  switch_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               gcnt_d = gcnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            owner_d = OWN_NONE;
            grant_d = 3'b000;
            busy_d  = 1'b0;
            cnt_d   = '0;
            gcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_NONE;
         last_q   <= OWN_C;
         cnt_q    <= '0;
         gcnt_q   <= '0;
         grant_q  <= 3'b000;
         busy_q   <= 1'b0;
         switch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         gcnt_q   <= gcnt_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         switch_q <= switch_d;
      end
   end

   assign bus.GH     = grant_q[0];
   assign bus.GDC    = grant_q[1];
   assign bus.GC     = grant_q[2];
   assign bus.OWNER  = owner_q;
   assign bus.BUSY   = busy_q;
   assign bus.SWITCH = switch_q;

endmodule

// File: tb/tb_load_arbiter.sv
// tb/tb_load_arbiter.sv - directed self-checking bench for load_arbiter.
module tb_load_arbiter;

   logic CLK;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   load_arbiter_if bus ();

   load_arbiter #(
      .MIN_ON (4),
      .MAX_ON (16),
      .GAP    (2),
      .CW     (5)
   ) dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Expected {GH,GDC,GC,OWNER,BUSY,SWITCH} for a given owner code.
   function automatic logic [6:0] vec(input logic [1:0] own, input logic busy, input logic sw);
      return {own == 2'd1, own == 2'd2, own == 2'd3, own, busy, sw};
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [1:0] own, input logic busy, input logic sw);
      chk(tag, {bus.GH, bus.GDC, bus.GC, bus.OWNER, bus.BUSY, bus.SWITCH}, vec(own, busy, sw));
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      chk("onehot", {6'd0, ($countones({bus.GH, bus.GDC, bus.GC}) <= 1)}, 7'd1);
   endtask

   task automatic do_reset();
      bus.H   = 1'b0;
      bus.DC  = 1'b0;
      bus.C   = 1'b0;
      reset_n = 1'b0;
      @(posedge CLK);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      bus.H   = 1'b0;
      bus.DC  = 1'b0;
      bus.C   = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      expect_out("reset_state", 2'd0, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
      expect_out("reset_hold", 2'd0, 1'b0, 1'b0);
      reset_n = 1'b1;
      tick();
      expect_out("idle_no_req", 2'd0, 1'b0, 1'b0);

      // Single-cycle H pulse: minimum on-time, then gap, then idle.
      bus.H = 1'b1;
      tick();
      bus.H = 1'b0;
      expect_out("pulse_grant1", 2'd1, 1'b1, 1'b1);
      for (int k = 2; k <= 4; k++) begin
         tick();
         expect_out($sformatf("pulse_grant%0d", k), 2'd1, 1'b1, 1'b0);
      end
      tick();
      expect_out("pulse_gap1", 2'd0, 1'b1, 1'b0);
      tick();
      expect_out("pulse_gap2", 2'd0, 1'b1, 1'b0);
      tick();
      expect_out("pulse_idle", 2'd0, 1'b0, 1'b0);

      // All three requesting: 16-cycle slices in H, DC, C order.
      do_reset();
      bus.H  = 1'b1;
      bus.DC = 1'b1;
      bus.C  = 1'b1;
      for (int seg = 1; seg <= 3; seg++) begin
         for (int k = 1; k <= 16; k++) begin
            tick();
            expect_out($sformatf("rr_own%0d_c%0d", seg, k), 2'(seg), 1'b1, k == 1);
         end
         for (int g = 1; g <= 2; g++) begin
            tick();
            expect_out($sformatf("rr_gap%0d_%0d", seg, g), 2'd0, 1'b1, 1'b0);
         end
      end
      tick();
      expect_out("rr_wrap_h", 2'd1, 1'b1, 1'b1);

      // Sole requester keeps the grant past MAX_ON.
      do_reset();
      bus.DC = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         tick();
         expect_out($sformatf("sole_dc_c%0d", k), 2'd2, 1'b1, k == 1);
      end

      // H held 10 grant cycles while DC waits; DC follows after the gap.
      do_reset();
      bus.H = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         expect_out($sformatf("hold_h_c%0d", k), 2'd1, 1'b1, k == 1);
         if (k == 2) bus.DC = 1'b1;
      end
      bus.H = 1'b0;
      tick();
      expect_out("hold_gap1", 2'd0, 1'b1, 1'b0);
      tick();
      expect_out("hold_gap2", 2'd0, 1'b1, 1'b0);
      tick();
      expect_out("hold_dc_grant", 2'd2, 1'b1, 1'b1);

      // Asynchronous reset in the middle of a C grant.
      do_reset();
      bus.C = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         expect_out($sformatf("mid_c_c%0d", k), 2'd3, 1'b1, k == 1);
      end
      #2 reset_n = 1'b0;
      #1;
      expect_out("mid_reset_async", 2'd0, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
      bus.H   = 1'b1;
      bus.DC  = 1'b1;
      reset_n = 1'b1;
      tick();
      expect_out("post_reset_h_first", 2'd1, 1'b1, 1'b1);

      // Previous owner alone after the gap is re-granted.
      do_reset();
      bus.H = 1'b1;
      tick();
      bus.H = 1'b0;
      expect_out("regrant_c1", 2'd1, 1'b1, 1'b1);
      for (int k = 2; k <= 4; k++) begin
         tick();
         expect_out($sformatf("regrant_c%0d", k), 2'd1, 1'b1, 1'b0);
      end
      tick();
      expect_out("regrant_gap1", 2'd0, 1'b1, 1'b0);
      bus.H = 1'b1;
      tick();
      expect_out("regrant_gap2", 2'd0, 1'b1, 1'b0);
      tick();
      expect_out("regrant_h", 2'd1, 1'b1, 1'b1);
      tick();
      expect_out("regrant_h_hold", 2'd1, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
